// File: rtl/serial_add_ctrl_if.sv
// Request/result handshake plus the pins to the shared single-bit full adder.
// master = requester and adder model side, slave = the sequencer.
interface serial_add_ctrl_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_y;
    logic             fa_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, fa_y, fa_cout,
        input  fa_a, fa_b, fa_cin, busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, fa_y, fa_cout,
        output fa_a, fa_b, fa_cin, busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: streams operands LSB first through one shared full adder.
// States: IDLE waits for start, RUN feeds one bit per clock, DONE pulses done for one cycle.
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_add_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        bus.fa_a   = 1'b0;
        bus.fa_b   = 1'b0;
        bus.fa_cin = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_a_d  = bus.a;
                    op_b_d  = bus.b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                bus.busy   = 1'b1;
                bus.fa_a   = op_a_q[0];
                bus.fa_b   = op_b_q[0];
                bus.fa_cin = carry_q;
                op_a_d     = op_a_q >> 1;
                op_b_d     = op_b_q >> 1;
                // Adder result enters at the MSB so the LSB lands in bit 0 after WIDTH shifts.
                sum_d      = {bus.fa_y, sum_q[WIDTH-1:1]};
                carry_d    = bus.fa_cout;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d  = bus.fa_cout;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench: behavioural full adder on the fa_* pins, results checked
// against plain integer addition of the operands.
module tb_serial_add_ctrl;
    localparam int W = 4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   cyc;

    serial_add_ctrl_if #(.WIDTH(W)) ifc ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    assign ifc.fa_y    = ifc.fa_a ^ ifc.fa_b ^ ifc.fa_cin;
    assign ifc.fa_cout = (ifc.fa_a & ifc.fa_b) | (ifc.fa_a & ifc.fa_cin) | (ifc.fa_b & ifc.fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full addition with drive-pattern checks; leaves the bench in the first IDLE cycle after done.
    task automatic run_add(input int a, input int b, input string tag);
        int total, exp_sum, exp_cout, mask, carry_in, ab, bb;
        total    = a + b;
        exp_sum  = total % (1 << W);
        exp_cout = total >> W;
        ifc.start = 1'b1;
        ifc.a = W'(a);
        ifc.b = W'(b);
        step();
        ifc.start = 1'b0;
        ifc.a = W'($urandom);
        ifc.b = W'($urandom);
        for (int i = 0; i < W; i++) begin
            mask     = (1 << i) - 1;
            carry_in = (((a & mask) + (b & mask)) >> i) & 1;
            ab       = (a >> i) & 1;
            bb       = (b >> i) & 1;
            tests++;
            if (ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
                fails++;
                $display("FAIL %s run%0d busy/done: got %b/%b want 1/0", tag, i, ifc.busy, ifc.done);
            end
            tests++;
            if ({ifc.fa_a, ifc.fa_b, ifc.fa_cin} !== {ab[0], bb[0], carry_in[0]}) begin
                fails++;
                $display("FAIL %s drive%0d: got %b%b%b want %0d%0d%0d", tag, i,
                         ifc.fa_a, ifc.fa_b, ifc.fa_cin, ab, bb, carry_in);
            end
            step();
        end
        tests++;
        if (ifc.done !== 1'b1 || ifc.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s done_cycle busy/done: got %b/%b want 0/1", tag, ifc.busy, ifc.done);
        end
        tests++;
        if (ifc.sum !== W'(exp_sum) || ifc.cout !== exp_cout[0]) begin
            fails++;
            $display("FAIL %s result: got sum=%0d cout=%b want sum=%0d cout=%0d", tag,
                     ifc.sum, ifc.cout, exp_sum, exp_cout);
        end
        tests++;
        if ({ifc.fa_a, ifc.fa_b, ifc.fa_cin} !== 3'b000) begin
            fails++;
            $display("FAIL %s drive_in_done: got %b%b%b want 000", tag, ifc.fa_a, ifc.fa_b, ifc.fa_cin);
        end
        step();
        tests++;
        if (ifc.done !== 1'b0 || ifc.busy !== 1'b0 || ifc.sum !== W'(exp_sum) ||
            ifc.cout !== exp_cout[0] || {ifc.fa_a, ifc.fa_b, ifc.fa_cin} !== 3'b000) begin
            fails++;
            $display("FAIL %s idle_hold: got done=%b busy=%b sum=%0d cout=%b fa=%b%b%b want 0 0 %0d %0d 000",
                     tag, ifc.done, ifc.busy, ifc.sum, ifc.cout, ifc.fa_a, ifc.fa_b, ifc.fa_cin,
                     exp_sum, exp_cout);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.start = 1'b0;
        ifc.a = '0;
        ifc.b = '0;
        step();
        step();
        tests++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.sum !== '0 || ifc.cout !== 1'b0 ||
            {ifc.fa_a, ifc.fa_b, ifc.fa_cin} !== 3'b000) begin
            fails++;
            $display("FAIL reset_state: got busy=%b done=%b sum=%0d cout=%b fa=%b%b%b want all 0",
                     ifc.busy, ifc.done, ifc.sum, ifc.cout, ifc.fa_a, ifc.fa_b, ifc.fa_cin);
        end
        // Start together with reset must not be accepted.
        ifc.start = 1'b1;
        ifc.a = 4'd5;
        ifc.b = 4'd5;
        step();
        rst = 1'b0;
        ifc.start = 1'b0;
        tests++;
        if (ifc.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_vs_start: got busy=%b want 0", ifc.busy);
        end
        step();
        tests++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
            fails++;
            $display("FAIL reset_vs_start_late: got busy=%b done=%b want 0/0", ifc.busy, ifc.done);
        end
    endtask

    task automatic test_directed();
        run_add(3, 5, "basic");
        repeat (3) step();
        tests++;
        if (ifc.sum !== 4'd8 || ifc.cout !== 1'b0) begin
            fails++;
            $display("FAIL basic_hold: got sum=%0d cout=%b want 8/0", ifc.sum, ifc.cout);
        end
        run_add(15, 1, "wrap15_1");
        run_add(15, 15, "wrap15_15");
        run_add(0, 0, "zero");
        run_add(6, 3, "drive6_3");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            run_add(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "random");
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    task automatic test_ignored_start();
        ifc.start = 1'b1;
        ifc.a = 4'd2;
        ifc.b = 4'd2;
        step();
        ifc.start = 1'b0;
        step();
        ifc.start = 1'b1;
        ifc.a = 4'd7;
        ifc.b = 4'd7;
        step();
        ifc.start = 1'b0;
        step();
        step();
        tests++;
        if (ifc.done !== 1'b1 || ifc.sum !== 4'd4 || ifc.cout !== 1'b0) begin
            fails++;
            $display("FAIL ignore_run: got done=%b sum=%0d cout=%b want 1/4/0", ifc.done, ifc.sum, ifc.cout);
        end
        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
        tests++;
        if (ifc.done !== 1'b0 || ifc.busy !== 1'b0 || ifc.sum !== 4'd4) begin
            fails++;
            $display("FAIL ignore_done_cycle: got done=%b busy=%b sum=%0d want 0/0/4", ifc.done, ifc.busy, ifc.sum);
        end
        step();
        tests++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
            fails++;
            $display("FAIL ignore_no_queue: got busy=%b done=%b want 0/0", ifc.busy, ifc.done);
        end
        run_add(12, 9, "after_ignore");
    endtask

    task automatic test_reset_mid_op();
        bit seen_done;
        ifc.start = 1'b1;
        ifc.a = 4'd9;
        ifc.b = 4'd9;
        step();
        ifc.start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.sum !== '0 || ifc.cout !== 1'b0) begin
            fails++;
            $display("FAIL midrst_clear: got busy=%b done=%b sum=%0d cout=%b want 0/0/0/0",
                     ifc.busy, ifc.done, ifc.sum, ifc.cout);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ifc.done === 1'b1 || ifc.busy === 1'b1) seen_done = 1'b1;
        end
        tests++;
        if (seen_done !== 1'b0) begin
            fails++;
            $display("FAIL midrst_no_done: got activity=%b want 0", seen_done);
        end
        run_add(1, 1, "after_midrst");
    endtask

    task automatic test_back_to_back();
        int first_done, second_done, budget;
        ifc.start = 1'b1;
        ifc.a = 4'd1;
        ifc.b = 4'd1;
        step();
        ifc.start = 1'b0;
        budget = 0;
        while (ifc.done !== 1'b1 && budget < 20) begin
            step();
            budget++;
        end
        first_done = cyc;
        tests++;
        if (ifc.done !== 1'b1 || ifc.sum !== 4'd2) begin
            fails++;
            $display("FAIL b2b_first: got done=%b sum=%0d want 1/2", ifc.done, ifc.sum);
        end
        step();
        ifc.start = 1'b1;
        ifc.a = 4'd10;
        ifc.b = 4'd7;
        step();
        ifc.start = 1'b0;
        budget = 0;
        while (ifc.done !== 1'b1 && budget < 20) begin
            step();
            budget++;
        end
        second_done = cyc;
        tests++;
        if (ifc.done !== 1'b1 || second_done - first_done != 6) begin
            fails++;
            $display("FAIL b2b_spacing: got done=%b gap=%0d want 1/6", ifc.done, second_done - first_done);
        end
        tests++;
        if (ifc.sum !== 4'd1 || ifc.cout !== 1'b1) begin
            fails++;
            $display("FAIL b2b_result: got sum=%0d cout=%b want 1/1", ifc.sum, ifc.cout);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        ifc.start = 1'b0;
        ifc.a = '0;
        ifc.b = '0;
        test_reset();
        test_directed();
        test_random();
        test_ignored_start();
        test_reset_mid_op();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
